// File: rtl/i2c_slave_regs.sv
// I2C target with an 8-byte register bank, a host port and auto-increment.
// Define I2C_S_GLITCH_FILTER_EN to add a 3-sample majority filter.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         NREGS_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  input  logic                  cs,
  input  logic                  write,
  input  logic [NREGS_LOG2-1:0] reg_addr,
  input  logic [7:0]            wr_data,
  output logic [7:0]            rd_data,
  output logic                  busy,
  output logic                  wr_evt,
  output logic [NREGS_LOG2-1:0] wr_evt_addr
);

  localparam int NREGS = 1 << NREGS_LOG2;
  localparam logic [NREGS_LOG2-1:0] PTR_ONE = 1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } state_t;

  logic [1:0] scl_sy;
  logic [1:0] sda_sy;
  logic       scl_c;
  logic       sda_c;
  logic       scl_d;
  logic       sda_d;
  logic [4:0] prime;

  // two-flop synchronizers, idle-high after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sy <= 2'b11;
      sda_sy <= 2'b11;
    end else begin
      scl_sy <= {scl_sy[0], scl_i};
      sda_sy <= {sda_sy[0], sda_i};
    end
  end

`ifdef I2C_S_GLITCH_FILTER_EN
  logic [1:0] scl_h;
  logic [1:0] sda_h;

  // majority of three consecutive samples rejects 1-clk pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_h <= 2'b11;
      sda_h <= 2'b11;
      scl_c <= 1'b1;
      sda_c <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_sy[1]};
      sda_h <= {sda_h[0], sda_sy[1]};
      scl_c <= (scl_sy[1] & scl_h[0]) |
               (scl_sy[1] & scl_h[1]) |
               (scl_h[0] & scl_h[1]);
      sda_c <= (sda_sy[1] & sda_h[0]) |
               (sda_sy[1] & sda_h[1]) |
               (sda_h[0] & sda_h[1]);
    end
  end
`else
  assign scl_c = scl_sy[1];
  assign sda_c = sda_sy[1];
`endif

  // edge reference copies; prime masks edges until the pipe holds real pin data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
      prime <= '0;
    end else begin
      scl_d <= scl_c;
      sda_d <= sda_c;
      prime <= {prime[3:0], 1'b1};
    end
  end

  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  assign scl_rise = prime[4] & scl_c & ~scl_d;
  assign scl_fall = prime[4] & ~scl_c & scl_d;
  assign start = prime[4] & scl_c & scl_d & sda_d & ~sda_c;
  assign stop = prime[4] & scl_c & scl_d & ~sda_d & sda_c;

  logic [7:0]            regs [NREGS];
  state_t                state;
  state_t                state_n;
  logic [3:0]            cnt;
  logic [3:0]            cnt_n;
  logic [7:0]            sh;
  logic [7:0]            sh_n;
  logic [7:0]            tx;
  logic [7:0]            tx_n;
  logic [NREGS_LOG2-1:0] ptr;
  logic [NREGS_LOG2-1:0] ptr_n;
  logic                  drv;
  logic                  drv_n;
  logic                  busy_n;
  logic                  we;
  logic [7:0]            sh_in;

  assign sh_in = {sh[6:0], sda_c};
  assign rd_data = regs[reg_addr];

  // protocol state register; sda_oe trails drv by one clk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      sh     <= '0;
      tx     <= '0;
      ptr    <= '0;
      drv    <= 1'b0;
      busy   <= 1'b0;
      sda_oe <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sh     <= sh_n;
      tx     <= tx_n;
      ptr    <= ptr_n;
      drv    <= drv_n;
      busy   <= busy_n;
      sda_oe <= drv;
    end
  end

  // next-state: bits counted on SCL rise, decisions taken on SCL fall
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    tx_n    = tx;
    ptr_n   = ptr;
    drv_n   = drv;
    busy_n  = busy;
    we      = 1'b0;
    if (stop) begin
      state_n = IDLE;
      drv_n   = 1'b0;
      busy_n  = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      cnt_n   = '0;
      drv_n   = 1'b0;
    end else begin
      unique case (state)
        ADDR, PTR, WR_BYTE: begin
          if (scl_rise) begin
            sh_n  = sh_in;
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7 && state == PTR)
              ptr_n = sh_in[NREGS_LOG2-1:0];
            if (cnt == 4'd7 && state == WR_BYTE) begin
              we    = 1'b1;
              ptr_n = ptr + PTR_ONE;
            end
          end else if (scl_fall && cnt == 4'd8) begin
            cnt_n = '0;
            if (state != ADDR) begin
              state_n = WR_ACK;
              drv_n   = 1'b1;
            end else if (sh[7:1] == SLAVE_ADDR) begin
              state_n = ADDR_ACK;
              drv_n   = 1'b1;
              busy_n  = 1'b1;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise) begin
            cnt_n = 4'd1;
          end else if (scl_fall && cnt == 4'd1) begin
            cnt_n = '0;
            if (sh[0]) begin
              state_n = RD_BYTE;
              tx_n    = regs[ptr];
              drv_n   = ~regs[ptr][7];
            end else begin
              state_n = PTR;
              drv_n   = 1'b0;
            end
          end
        end
        WR_ACK: begin
          if (scl_rise) begin
            cnt_n = 4'd1;
          end else if (scl_fall && cnt == 4'd1) begin
            cnt_n   = '0;
            state_n = WR_BYTE;
            drv_n   = 1'b0;
          end
        end
        RD_BYTE: begin
          if (scl_rise) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            cnt_n   = '0;
            state_n = RD_ACK;
            drv_n   = 1'b0;
            ptr_n   = ptr + PTR_ONE;
          end else if (scl_fall && cnt != 4'd0) begin
            tx_n  = {tx[6:0], tx[7]};
            drv_n = ~tx[6];
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            cnt_n = 4'd1;
            sh_n  = sh_in;
          end else if (scl_fall && cnt == 4'd1) begin
            cnt_n = '0;
            if (!sh[0]) begin
              state_n = RD_BYTE;
              tx_n    = regs[ptr];
              drv_n   = ~regs[ptr][7];
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        IDLE, WAIT_STOP: begin
          drv_n = 1'b0;
        end
        default: begin
          state_n = IDLE;
          drv_n   = 1'b0;
        end
      endcase
    end
  end

  // register bank: host write is applied last so it wins a same-clk clash
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      wr_evt      <= 1'b0;
      wr_evt_addr <= '0;
    end else begin
      wr_evt <= we;
      if (we) begin
        wr_evt_addr <= ptr;
        regs[ptr]   <= sh_in;
      end
      if (cs && write)
        regs[reg_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bus master model on a wired-AND SDA.
// Glitch step runs only when I2C_S_GLITCH_FILTER_EN is defined.
module tb_i2c_slave_regs;

  localparam int T = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       cs = 1'b0;
  logic       write = 1'b0;
  logic [2:0] reg_addr = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       busy;
  logic       wr_evt;
  logic [2:0] wr_evt_addr;

  int total = 0;
  int bad = 0;
  logic [2:0] evq[$];
  logic ack;
  logic [7:0] rb;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regs #(
    .SLAVE_ADDR(7'h42),
    .NREGS_LOG2(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .scl_i(scl_i),
    .sda_i(sda_i),
    .sda_oe(sda_oe),
    .cs(cs),
    .write(write),
    .reg_addr(reg_addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .busy(busy),
    .wr_evt(wr_evt),
    .wr_evt_addr(wr_evt_addr)
  );

  always @(negedge clk)
    if (reset && wr_evt)
      evq.push_back(wr_evt_addr);

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish (bad=%0d)", bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    tick(T);
    scl_m = 1'b1;
    tick(T);
    sda_m = 1'b0;
    tick(T);
    scl_m = 1'b0;
    tick(T);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    tick(T);
    scl_m = 1'b1;
    tick(T);
    sda_m = 1'b1;
    tick(T);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      tick(T);
      scl_m = 1'b1;
      tick(T);
      scl_m = 1'b0;
      tick(T);
    end
    sda_m = 1'b1;
    tick(T);
    scl_m = 1'b1;
    tick(T);
    a = sda_i;
    scl_m = 1'b0;
    tick(T);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic a);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(T);
      scl_m = 1'b1;
      tick(T);
      b[i] = sda_i;
      scl_m = 1'b0;
    end
    tick(T);
    sda_m = a;
    tick(T);
    scl_m = 1'b1;
    tick(T);
    scl_m = 1'b0;
    tick(T);
  endtask

  task automatic hwr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1;
    write = 1'b1;
    reg_addr = a;
    wr_data = d;
    tick(1);
    cs = 1'b0;
    write = 1'b0;
  endtask

  task automatic hrd(input logic [2:0] a, output logic [7:0] d);
    reg_addr = a;
    tick(1);
    d = rd_data;
  endtask

  initial begin
    #2 reset = 1'b0;
    tick(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_evt", wr_evt, 0);
    chk("rst_wr_evt_addr", wr_evt_addr, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    reset = 1'b1;
    tick(10);

    // write burst with pointer wrap
    bus_start();
    send_byte(8'h84, ack);
    chk("wb_addr_ack", ack, 0);
    chk("wb_busy", busy, 1);
    send_byte(8'h06, ack);
    chk("wb_ptr_ack", ack, 0);
    send_byte(8'hA1, ack);
    chk("wb_d0_ack", ack, 0);
    send_byte(8'hB2, ack);
    chk("wb_d1_ack", ack, 0);
    send_byte(8'hC3, ack);
    chk("wb_d2_ack", ack, 0);
    bus_stop();
    tick(10);
    chk("wb_busy_end", busy, 0);
    hrd(3'd6, rb);
    chk("wb_reg6", rb, 8'hA1);
    hrd(3'd7, rb);
    chk("wb_reg7", rb, 8'hB2);
    hrd(3'd0, rb);
    chk("wb_reg0", rb, 8'hC3);
    chk("wb_evt_n", evq.size(), 3);
    if (evq.size() == 3) begin
      chk("wb_evt0", evq[0], 6);
      chk("wb_evt1", evq[1], 7);
      chk("wb_evt2", evq[2], 0);
    end
    evq.delete();

    // read burst through repeated start
    hwr(3'd2, 8'h5A);
    hwr(3'd3, 8'h3C);
    hrd(3'd2, rb);
    chk("rb_host_reg2", rb, 8'h5A);
    bus_start();
    send_byte(8'h84, ack);
    chk("rb_addr_ack", ack, 0);
    send_byte(8'h02, ack);
    chk("rb_ptr_ack", ack, 0);
    bus_start();
    send_byte(8'h85, ack);
    chk("rb_raddr_ack", ack, 0);
    recv_byte(rb, 1'b0);
    chk("rb_byte0", rb, 8'h5A);
    recv_byte(rb, 1'b1);
    chk("rb_byte1", rb, 8'h3C);
    chk("rb_oe_nack", sda_oe, 0);
    chk("rb_busy", busy, 1);
    bus_stop();
    tick(10);
    chk("rb_busy_end", busy, 0);
    chk("rb_no_evt", evq.size(), 0);

    // address mismatch
    bus_start();
    send_byte(8'h90, ack);
    chk("mm_addr_nack", ack, 1);
    chk("mm_busy", busy, 0);
    send_byte(8'h11, ack);
    chk("mm_data_nack", ack, 1);
    chk("mm_oe", sda_oe, 0);
    bus_stop();
    tick(10);
    chk("mm_busy_end", busy, 0);
    hrd(3'd1, rb);
    chk("mm_reg1", rb, 8'h00);
    hrd(3'd0, rb);
    chk("mm_reg0", rb, 8'hC3);
    chk("mm_no_evt", evq.size(), 0);

    // host and bus write reg4 in the same clk
    bus_start();
    send_byte(8'h84, ack);
    chk("cf_addr_ack", ack, 0);
    send_byte(8'h04, ack);
    chk("cf_ptr_ack", ack, 0);
    cs = 1'b1;
    write = 1'b1;
    reg_addr = 3'd4;
    wr_data = 8'hEE;
    fork
      send_byte(8'h77, ack);
      begin
        int n;
        n = 0;
        while (!wr_evt && n < 4000) begin
          tick(1);
          n++;
        end
        cs = 1'b0;
        write = 1'b0;
        chk("cf_evt_seen", wr_evt, 1);
      end
    join
    chk("cf_data_ack", ack, 0);
    bus_stop();
    tick(10);
    hrd(3'd4, rb);
    chk("cf_reg4", rb, 8'hEE);
    chk("cf_evt_n", evq.size(), 1);
    if (evq.size() == 1)
      chk("cf_evt_addr", evq[0], 4);
    evq.delete();

    // reset during the 5th bit of a read
    hwr(3'd5, 8'h00);
    bus_start();
    send_byte(8'h84, ack);
    send_byte(8'h05, ack);
    chk("ab_ptr_ack", ack, 0);
    bus_start();
    send_byte(8'h85, ack);
    chk("ab_raddr_ack", ack, 0);
    sda_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(T);
      scl_m = 1'b1;
      tick(T);
      scl_m = 1'b0;
    end
    tick(T);
    chk("ab_oe_pre", sda_oe, 1);
    reset = 1'b0;
    #1;
    chk("ab_oe_rst", sda_oe, 0);
    chk("ab_busy_rst", busy, 0);
    tick(2);
    bus_stop();
    tick(5);
    reset = 1'b1;
    tick(10);
    chk("ab_busy_after", busy, 0);
    hrd(3'd0, rb);
    chk("ab_reg0_clr", rb, 8'h00);
    bus_start();
    send_byte(8'h84, ack);
    chk("ab_w_addr_ack", ack, 0);
    send_byte(8'h01, ack);
    chk("ab_w_ptr_ack", ack, 0);
    send_byte(8'h99, ack);
    chk("ab_w_data_ack", ack, 0);
    bus_stop();
    tick(10);
    hrd(3'd1, rb);
    chk("ab_reg1", rb, 8'h99);
    chk("ab_evt_n", evq.size(), 1);
    if (evq.size() == 1)
      chk("ab_evt_addr", evq[0], 1);
    evq.delete();

`ifdef I2C_S_GLITCH_FILTER_EN
    // 1-clk SDA low while SCL high must not look like START
    tick(20);
    sda_m = 1'b0;
    tick(1);
    sda_m = 1'b1;
    tick(20);
    chk("gl_busy", busy, 0);
    send_byte(8'h84, ack);
    chk("gl_no_ack", ack, 1);
    bus_stop();
    tick(10);
    chk("gl_busy_end", busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
